// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Optional lock feature is enabled with REGFILE_ARB_LOCK_EN.
package regfile_pkg;

    localparam int NREGS     = 12;
    localparam int AW        = 4;
    localparam int DW        = 8;
    localparam int ERR_CNT_W = 8;
    localparam int LOCK_MAX  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from last_grant+1, wrapping modulo NREQ; last_grant itself has lowest priority.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            found,
    output logic [IW-1:0]   winner
);

    logic [IW-1:0] idx;

    // Walk from the farthest offset to the nearest so the nearest hit wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = IW'((int'(last_grant) + off) % NREQ);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ requesters.
// Define REGFILE_ARB_LOCK_EN to add the LOCK input (bounded grant locking).
module regfile_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int AW    = regfile_pkg::AW,
    parameter int DW    = regfile_pkg::DW,
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   REQ,
    input  logic [NREQ*AW-1:0]                ADDR,
    input  logic [NREQ*DW-1:0]                DATA,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [NREQ-1:0]                   LOCK,
`endif
    output logic [NREQ-1:0]                   ACK,
    output logic                              ERR,
    output logic                              WR,
    output logic [AW-1:0]                     SEL,
    output logic [DW-1:0]                     DOUT,
    output logic                              BUSY,
    output logic [regfile_pkg::ERR_CNT_W-1:0] ERR_CNT
);

    import regfile_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t                 state_q, state_d;
    logic [IW-1:0]          last_grant_q, last_grant_d;
    logic                   wr_q, wr_d;
    logic [AW-1:0]          sel_q, sel_d;
    logic [DW-1:0]          dout_q, dout_d;
    logic [NREQ-1:0]        ack_q, ack_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [NREQ-1:0]        eligible;
    logic                   rr_found;
    logic [IW-1:0]          rr_winner;
    logic                   grant;
    logic [IW-1:0]          gnt_idx;
    logic [AW-1:0]          gnt_addr;

    // The requester in its ACK cycle is still holding REQ at the closing edge.
    assign eligible = REQ & ~ack_q;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req        (eligible),
        .last_grant (last_grant_q),
        .found      (rr_found),
        .winner     (rr_winner)
    );

`ifdef REGFILE_ARB_LOCK_EN
    logic [2:0] run_q, run_d;
    logic       keep;

    // A locked winner keeps the port, bypassing masking, for at most LOCK_MAX grants.
    assign keep = (state_q == ISSUE) && LOCK[last_grant_q] && REQ[last_grant_q]
                  && (int'(run_q) < LOCK_MAX);
`endif

    always_comb begin
        grant   = rr_found;
        gnt_idx = rr_winner;
`ifdef REGFILE_ARB_LOCK_EN
        run_d = run_q;
        if (keep) begin
            grant   = 1'b1;
            gnt_idx = last_grant_q;
            run_d   = run_q + 3'd1;
        end else if (rr_found) begin
            run_d = 3'd1;
        end
`endif
        gnt_addr = ADDR[int'(gnt_idx)*AW +: AW];

        state_d      = IDLE;
        last_grant_d = last_grant_q;
        wr_d         = 1'b0;
        sel_d        = '0;
        dout_d       = '0;
        ack_d        = '0;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;

        if (grant) begin
            state_d          = ISSUE;
            last_grant_d     = gnt_idx;
            ack_d[gnt_idx]   = 1'b1;
            sel_d            = gnt_addr;
            dout_d           = DATA[int'(gnt_idx)*DW +: DW];
            // Out-of-range targets are acknowledged with ERR and never strobed.
            if (int'(gnt_addr) < NREGS) begin
                wr_d = 1'b1;
            end else begin
                err_d     = 1'b1;
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NREQ - 1);
            wr_q         <= 1'b0;
            sel_q        <= '0;
            dout_q       <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
`ifdef REGFILE_ARB_LOCK_EN
            run_q        <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            sel_q        <= sel_d;
            dout_q       <= dout_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
`ifdef REGFILE_ARB_LOCK_EN
            run_q        <= run_d;
`endif
        end
    end

    assign ACK     = ack_q;
    assign ERR     = err_q;
    assign WR      = wr_q;
    assign SEL     = sel_q;
    assign DOUT    = dout_q;
    assign BUSY    = (state_q == ISSUE);
    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural round-robin model.
module tb_regfile_write_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int NREGS = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_v;
    logic [NREQ*AW-1:0]  addr_v;
    logic [NREQ*DW-1:0]  data_v;
    logic [NREQ-1:0]     lock_v;
    logic [NREQ-1:0]     ACK;
    logic                ERR, WR, BUSY;
    logic [AW-1:0]       SEL;
    logic [DW-1:0]       DOUT;
    logic [7:0]          ERR_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(NREGS)) dut (
        .clk     (clk),
        .rst     (rst),
        .REQ     (req_v),
        .ADDR    (addr_v),
        .DATA    (data_v),
`ifdef REGFILE_ARB_LOCK_EN
        .LOCK    (lock_v),
`endif
        .ACK     (ACK),
        .ERR     (ERR),
        .WR      (WR),
        .SEL     (SEL),
        .DOUT    (DOUT),
        .BUSY    (BUSY),
        .ERR_CNT (ERR_CNT)
    );

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*AW-1:0] addr;
        logic [NREQ*DW-1:0] data;
        logic [NREQ-1:0]    ack;
        logic               wr;
        logic [AW-1:0]      sel;
        logic [DW-1:0]      dout;
        logic               err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        req_v  = '0;
        addr_v = '0;
        data_v = '0;
        lock_v = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        int              m_last, m_prev, m_cnt, win, idx;
        logic [AW-1:0]   a;
        logic [NREQ-1:0] drop_next;
        reset_dut();
        m_last = NREQ - 1;
        m_prev = -1;
        m_cnt  = 0;
        drop_next = '0;
        for (int c = 0; c < cycles; c++) begin
            win = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (win < 0 && req_v[idx] && idx != m_prev) win = idx;
            end
            if (win >= 0) a = addr_v[win*AW +: AW];
            tick();
            if (win >= 0) begin
                if (a >= NREGS && m_cnt < 255) m_cnt++;
                check("rnd_ack", ACK, 32'(1) << win);
                check("rnd_wr", WR, a < NREGS);
                check("rnd_err", ERR, a >= NREGS);
                check("rnd_sel", SEL, a);
                check("rnd_dout", DOUT, data_v[win*DW +: DW]);
                check("rnd_busy", BUSY, 1);
                m_last = win;
            end else begin
                check("rnd_ack_idle", ACK, 0);
                check("rnd_wr_idle", WR, 0);
                check("rnd_busy_idle", BUSY, 0);
            end
            m_prev = win;
            check("rnd_err_cnt", ERR_CNT, m_cnt);
            if (WR) check("rnd_sel_valid", SEL < NREGS, 1);
            for (int i = 0; i < NREQ; i++) begin
                if (drop_next[i]) begin
                    req_v[i] = 1'b0;
                    drop_next[i] = 1'b0;
                end else if (ACK[i]) begin
                    if ($urandom_range(0, 1) == 1) req_v[i] = 1'b0;
                    else drop_next[i] = 1'b1;
                end else if (req_v[i]) begin
                    if ($urandom_range(0, 15) == 0) req_v[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_v[i] = 1'b1;
                    addr_v[i*AW +: AW] = AW'($urandom_range(0, 15));
                    data_v[i*DW +: DW] = DW'($urandom);
                end
            end
        end
        req_v = '0;
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0001, 16'h0005, 32'h000000A5, 4'b0001, 1'b1, 4'h5, 8'hA5, 1'b0};
        vecs[1] = '{4'b1111, 16'h3210, 32'h44332211, 4'b0001, 1'b1, 4'h0, 8'h11, 1'b0};
        vecs[2] = '{4'b0100, 16'h0C00, 32'h005A0000, 4'b0100, 1'b0, 4'hC, 8'h5A, 1'b1};
        vecs[3] = '{4'b1000, 16'hB000, 32'h7E000000, 4'b1000, 1'b1, 4'hB, 8'h7E, 1'b0};
        vecs[4] = '{4'b1010, 16'h9070, 32'hF0003C00, 4'b0010, 1'b1, 4'h7, 8'h3C, 1'b0};
        vecs[5] = '{4'b0010, 16'h00F0, 32'h0000C300, 4'b0010, 1'b0, 4'hF, 8'hC3, 1'b1};

        reset_dut();
        check("rst_wr", WR, 0);
        check("rst_sel", SEL, 0);
        check("rst_dout", DOUT, 0);
        check("rst_ack", ACK, 0);
        check("rst_err", ERR, 0);
        check("rst_busy", BUSY, 0);
        check("rst_err_cnt", ERR_CNT, 0);

        // Single-grant vectors, each from a fresh reset (requester 0 has priority).
        for (int v = 0; v < 6; v++) begin
            reset_dut();
            req_v  = vecs[v].req;
            addr_v = vecs[v].addr;
            data_v = vecs[v].data;
            tick();
            check($sformatf("vec%0d_ack", v), ACK, vecs[v].ack);
            check($sformatf("vec%0d_wr", v), WR, vecs[v].wr);
            check($sformatf("vec%0d_sel", v), SEL, vecs[v].sel);
            check($sformatf("vec%0d_dout", v), DOUT, vecs[v].dout);
            check($sformatf("vec%0d_err", v), ERR, vecs[v].err);
            check($sformatf("vec%0d_err_cnt", v), ERR_CNT, {7'd0, vecs[v].err});
            check($sformatf("vec%0d_busy", v), BUSY, 1);
            req_v = '0;
            tick();
            check($sformatf("vec%0d_idle_busy", v), BUSY, 0);
            check($sformatf("vec%0d_idle_ack", v), ACK, 0);
        end

        // All four request; each holds REQ through the edge ending its ACK cycle.
        reset_dut();
        addr_v = 16'h3210;
        data_v = 32'hD3C2B1A0;
        req_v  = 4'b1111;
        begin
            logic [NREQ-1:0] drop_next;
            drop_next = '0;
            for (int g = 0; g < 5; g++) begin
                tick();
                req_v = req_v & ~drop_next;
                drop_next = ACK;
                if (g < 4) begin
                    check($sformatf("b2b_ack%0d", g), ACK, 32'(1) << g);
                    check($sformatf("b2b_wr%0d", g), WR, 1);
                    check($sformatf("b2b_sel%0d", g), SEL, g);
                end else begin
                    check("b2b_no_regrant", ACK, 0);
                    check("b2b_idle", BUSY, 0);
                end
            end
        end
        req_v = '0;
        tick();

        // Error pulse and ERR_CNT saturation with a continuously rejected requester.
        reset_dut();
        addr_v = 16'h0C00;
        req_v  = 4'b0100;
        for (int j = 1; j <= 256; j++) begin
            int waited;
            waited = 0;
            while (!ACK[2] && waited < 4) begin
                tick();
                waited++;
            end
            if (!ACK[2]) begin
                check("err_sat_ack_timeout", ACK[2], 1);
                break;
            end
            if (j == 1) begin
                check("err_first_ack", ACK, 4'b0100);
                check("err_first_err", ERR, 1);
                check("err_first_wr", WR, 0);
                check("err_first_cnt", ERR_CNT, 1);
            end
            if (j == 255) check("err_cnt_255", ERR_CNT, 255);
            if (j == 256) begin
                check("err_cnt_sat", ERR_CNT, 255);
                check("err_sat_err", ERR, 1);
            end
            tick();
        end
        req_v = '0;
        tick();

        // Fairness: after a grant to 3, requester 0 beats 3, then 3 follows.
        reset_dut();
        addr_v = 16'h2001;
        req_v  = 4'b1000;
        tick();
        check("fair_pre_ack", ACK, 4'b1000);
        req_v = '0;
        tick();
        req_v = 4'b1001;
        tick();
        check("fair_first", ACK, 4'b0001);
        req_v[0] = 1'b0;
        tick();
        check("fair_second", ACK, 4'b1000);
        check("fair_second_sel", SEL, 2);
        req_v = '0;
        tick();
        check("fair_idle", BUSY, 0);

        // Asynchronous reset in the middle of an ISSUE cycle.
        reset_dut();
        addr_v = 16'h1003;
        req_v  = 4'b0001;
        tick();
        req_v = 4'b1001;
        tick();
        check("arst_pre_ack", ACK, 4'b1000);
        #2 rst = 1'b1;
        #1;
        check("arst_wr", WR, 0);
        check("arst_ack", ACK, 0);
        check("arst_busy", BUSY, 0);
        req_v = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        req_v = 4'b1001;
        tick();
        check("arst_prio0", ACK, 4'b0001);
        req_v = '0;
        tick();

`ifdef REGFILE_ARB_LOCK_EN
        // Requester 1 locks for four grants, then requester 2 is served.
        reset_dut();
        addr_v = 16'h0450;
        lock_v = 4'b0010;
        req_v  = 4'b0110;
        for (int g = 0; g < 5; g++) begin
            tick();
            check($sformatf("lock_grant%0d", g), ACK, (g < 4) ? 4'b0010 : 4'b0100);
            if (g == 3) req_v[1] = 1'b0;
            if (g == 4) req_v[2] = 1'b0;
        end
        lock_v = '0;
        tick();
`endif

        run_random(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
